seq_mult_param: RTL and testbench

- Parametrised radix-2 shift-add sequential multiplier; next generation of the team's fixed 32-bit sequential multiplier.
- Adds configurable operand width and a per-operation signed/unsigned mode.
- Adds valid/ready handshakes on input and output, deterministic latency and a held result.
- Sits between an operand-issuing controller and a result consumer in the multiplier datapath.

---
 rtl/seq_mult_param.sv | 127 ++++++++++++
 tb/tb_seq_mult_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Radix-2 shift-add sequential multiplier with configurable operand width,
// per-operation signed/unsigned mode and valid/ready handshakes on both sides.
module seq_mult_param #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int ACC_W = 2 * WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ACC_W-1:0]       acc_q, acc_d;
   logic [WIDTH-1:0]       mag_a_q, mag_a_d;
   logic                   neg_q, neg_d;
   logic [2*WIDTH-1:0]     result_q, result_d;
   logic [WIDTH:0]         sum_s;
   logic [ACC_W-1:0]       acc_next_s;

   // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
      if (sm && v[WIDTH-1]) begin
         magnitude = -v;
      end else begin
         magnitude = v;
      end
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      mag_a_d    = mag_a_q;
      neg_d      = neg_q;
      result_d   = result_q;
      sum_s      = '0;
      acc_next_s = '0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mag_a_d = magnitude(in_a, signed_mode);
               neg_d   = signed_mode & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
               acc_d   = {{(WIDTH + 1){1'b0}}, magnitude(in_b, signed_mode)};
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // acc[2W] is always zero between iterations, so it doubles as the sum's zero extension.
            if (acc_q[0]) begin
               sum_s = acc_q[ACC_W-1:WIDTH] + {1'b0, mag_a_q};
            end else begin
               sum_s = acc_q[ACC_W-1:WIDTH];
            end
            acc_next_s = {1'b0, sum_s, acc_q[WIDTH-1:1]};
            acc_d      = acc_next_s;
            cnt_d      = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               if (neg_q) begin
                  result_d = -acc_next_s[2*WIDTH-1:0];
               end else begin
                  result_d = acc_next_s[2*WIDTH-1:0];
               end
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mag_a_q  <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mag_a_q  <= mag_a_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_RUN);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: vector tables for WIDTH=32 and WIDTH=8
// instances plus hand-written back-pressure, mid-run reset and operand-change sequences.
module tb_seq_mult_param;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        iv32 = 1'b0, or32 = 1'b0, sm32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        ir32, ov32, busy32;
   logic [63:0] res32;

   logic        iv8 = 1'b0, or8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        ir8, ov8, busy8;
   logic [15:0] res8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_mult_param #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
      .signed_mode(sm32), .out_valid(ov32), .out_ready(or32), .result(res32), .busy(busy32)
   );

   seq_mult_param #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
      .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .result(res8), .busy(busy8)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sm;
      logic [63:0] p;
   } vec32_t;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sm;
      logic [15:0] p;
   } vec8_t;

   vec32_t v32[8];
   vec8_t  v8[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic accept32(input logic [31:0] a, input logic [31:0] b, input logic sm, input string nm);
      @(negedge clk);
      chk({nm, "_in_ready"}, {63'd0, ir32}, 64'd1);
      a32 = a; b32 = b; sm32 = sm; iv32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0;
   endtask

   task automatic wait_done32(output int cyc, input bit scramble);
      for (cyc = 1; cyc <= 40; cyc++) begin
         if (scramble) begin
            a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom_range(0, 1)); iv32 = 1'b1;
         end
         @(posedge clk); #1;
         if (ov32) break;
      end
      iv32 = 1'b0;
   endtask

   task automatic finish32(input string nm);
      or32 = 1'b1;
      @(posedge clk); #1;
      or32 = 1'b0;
      chk({nm, "_release"}, {62'd0, ov32, ir32}, 64'd1);
   endtask

   task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [63:0] exp, input string nm, input bit scramble);
      int cyc;
      accept32(a, b, sm, nm);
      chk({nm, "_busy"}, {63'd0, busy32}, 64'd1);
      wait_done32(cyc, scramble);
      chk({nm, "_latency"}, 64'(cyc), 64'd32);
      chk({nm, "_result"}, res32, exp);
      finish32(nm);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] exp, input string nm);
      int cyc;
      @(negedge clk);
      chk({nm, "_in_ready"}, {63'd0, ir8}, 64'd1);
      a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      for (cyc = 1; cyc <= 16; cyc++) begin
         @(posedge clk); #1;
         if (ov8) break;
      end
      chk({nm, "_latency"}, 64'(cyc), 64'd8);
      chk({nm, "_result"}, {48'd0, res8}, {48'd0, exp});
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      chk({nm, "_release"}, {62'd0, ov8, ir8}, 64'd1);
   endtask

   initial begin
      int cyc;
      int bad;

      v32[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
      v32[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
      v32[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
      v32[3] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000};
      v32[4] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780};
      v32[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
      v32[6] = '{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000};
      v32[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001};

      v8[0] = '{8'h80, 8'h80, 1'b0, 16'h4000};
      v8[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      v8[2] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
      v8[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      v8[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      v8[5] = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};
      v8[6] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset_state32", {res32, 1'b0}, 65'd0 >> 1);
      chk("reset_flags32", {61'd0, ir32, busy32, ov32}, 64'h4);
      chk("reset_state8", {48'd0, res8}, 64'd0);
      chk("reset_flags8", {61'd0, ir8, busy8, ov8}, 64'h4);

      for (int i = 0; i < 8; i++)
         op32(v32[i].a, v32[i].b, v32[i].sm, v32[i].p, $sformatf("v32_%0d", i), 1'b0);
      for (int i = 0; i < 7; i++)
         op8(v8[i].a, v8[i].b, v8[i].sm, v8[i].p, $sformatf("v8_%0d", i));

      // Back-pressure: held DONE must keep the result and refuse new operands.
      accept32(32'd3, 32'd5, 1'b0, "bp");
      wait_done32(cyc, 1'b0);
      chk("bp_latency", 64'(cyc), 64'd32);
      @(negedge clk);
      a32 = 32'd7; b32 = 32'd9; sm32 = 1'b0; iv32 = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (res32 !== 64'd15 || ir32 !== 1'b0 || ov32 !== 1'b1 || busy32 !== 1'b0) bad++;
      end
      chk("bp_stall_cycles_bad", 64'(bad), 64'd0);
      chk("bp_result", res32, 64'd15);
      @(negedge clk);
      or32 = 1'b1;
      @(posedge clk); #1;
      or32 = 1'b0;
      chk("bp_idle_after_release", {62'd0, ov32, ir32}, 64'd1);
      @(posedge clk); #1;
      iv32 = 1'b0;
      chk("bp_new_accept_busy", {63'd0, busy32}, 64'd1);
      wait_done32(cyc, 1'b0);
      chk("bp_new_latency", 64'(cyc), 64'd32);
      chk("bp_new_result", res32, 64'd63);
      finish32("bp_new");

      // Reset lands on the tenth iteration edge and discards the product.
      accept32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "rst");
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_result", res32, 64'd0);
      chk("rst_flags", {61'd0, ir32, busy32, ov32}, 64'h4);
      op32(32'd3, 32'd5, 1'b0, 64'd15, "rst_after", 1'b0);

      // Operands wiggle every RUN cycle; the product must follow only the accepted ones.
      op32(32'd12, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFDC, "chg", 1'b1);
      op32(32'd0, 32'h1234_5678, 1'b0, 64'd0, "zero", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
